// File: rtl/div_pkg.sv
// Shared constants and record types for the divider request sequencer.
package div_pkg;

  localparam int A_W     = 64;
  localparam int B_W     = 51;
  localparam int Q_W     = 32;
  localparam int DIV_LAT = 32;
  localparam int TAG_W   = 4;

  typedef struct packed {
    logic [Q_W-1:0]   q;
    logic [TAG_W-1:0] tag;
    logic             dz;
  } div_rsp_t;

  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] tag;
    logic             dz;
  } div_tag_stage_t;

  // Divide-by-zero results are reported as all-ones regardless of what the divider produced.
  function automatic logic [Q_W-1:0] fix_q(input logic [Q_W-1:0] q, input logic dz);
    return dz ? '1 : q;
  endfunction

endpackage

// File: rtl/div_rsp_fifo.sv
// First-word-fall-through FIFO with occupancy count; head reads as zero when empty.
module div_rsp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          pop, full;

  assign valid   = (cnt != '0);
  assign full    = (cnt == CW'(DEPTH));
  assign pop     = rd_en && valid;
  assign rd_data = valid ? mem[rptr] : '0;
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wr_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(wr_en && full));

endmodule

// File: rtl/div_req_sequencer.sv
// Valid/ready front end for the 32-stage divider: tag/valid delay line plus credit-limited response FIFO.
module div_req_sequencer
  import div_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [A_W-1:0]                req_a,
  input  logic [B_W-1:0]                req_b,
  input  logic [TAG_W-1:0]              req_tag,
  output logic [A_W-1:0]                div_a,
  output logic [B_W-1:0]                div_b,
  input  logic [Q_W-1:0]                div_q,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [Q_W-1:0]                rsp_q,
  output logic [TAG_W-1:0]              rsp_tag,
  output logic                          rsp_dz,
  output logic [$clog2(FIFO_DEPTH):0]   inflight
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  div_tag_stage_t pipe [DIV_LAT+1];
  logic [CW-1:0]  inflight_cnt, fifo_cnt;
  logic [CW:0]    credit_use;
  logic           accept, fifo_wr;
  div_rsp_t       wr_rsp, head;

  assign div_a = req_a;
  assign div_b = req_b;

  // Credits cover both in-flight and queued results, so the non-stallable divider never overruns the FIFO.
  assign credit_use = {1'b0, inflight_cnt} + {1'b0, fifo_cnt};
  assign req_ready  = !reset && (credit_use < (CW+1)'(FIFO_DEPTH));
  assign accept     = req_valid && req_ready;
  assign fifo_wr    = pipe[DIV_LAT].v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= DIV_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{v: accept, tag: req_tag, dz: (req_b == '0)};
      for (int i = 1; i <= DIV_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_cnt <= '0;
    end else begin
      case ({accept, fifo_wr})
        2'b10:   inflight_cnt <= inflight_cnt + 1'b1;
        2'b01:   inflight_cnt <= inflight_cnt - 1'b1;
        default: inflight_cnt <= inflight_cnt;
      endcase
    end
  end

  assign wr_rsp = '{q:   fix_q(div_q, pipe[DIV_LAT].dz),
                    tag: pipe[DIV_LAT].tag,
                    dz:  pipe[DIV_LAT].dz};

  div_rsp_fifo #(
    .W     ($bits(div_rsp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (wr_rsp),
    .rd_en   (rsp_ready),
    .rd_data (head),
    .valid   (rsp_valid),
    .count   (fifo_cnt)
  );

  assign rsp_q    = head.q;
  assign rsp_tag  = head.tag;
  assign rsp_dz   = head.dz;
  assign inflight = inflight_cnt;

endmodule

// File: tb/tb_div_req_sequencer.sv
// Bench for div_req_sequencer: divider stub, queue-based reference model checked every cycle, directed scenarios.
module tb_div_req_sequencer;
  import div_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [A_W-1:0]   req_a = '0;
  logic [B_W-1:0]   req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [A_W-1:0]   div_a;
  logic [B_W-1:0]   div_b;
  logic [Q_W-1:0]   div_q;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [Q_W-1:0]   rsp_q;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_dz;
  logic [CW-1:0]    inflight;

  always #5 clk = ~clk;

  div_req_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .div_a(div_a), .div_b(div_b), .div_q(div_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_q(rsp_q), .rsp_tag(rsp_tag), .rsp_dz(rsp_dz),
    .inflight(inflight)
  );

  // Divider stub: operand capture register, then DIV_LAT quotient registers.
  logic [A_W-1:0] opa;
  logic [B_W-1:0] opb;
  logic [63:0]    quo;
  logic [Q_W-1:0] qs [DIV_LAT];
  assign quo   = (opb == '0) ? 64'd0 : opa / {13'd0, opb};
  assign div_q = qs[DIV_LAT-1];
  always @(posedge clk) begin
    opa   <= div_a;
    opb   <= div_b;
    qs[0] <= quo[Q_W-1:0];
    for (int i = 1; i < DIV_LAT; i++) qs[i] <= qs[i-1];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each accept becomes an entry that enters the FIFO DIV_LAT+1 edges later.
  typedef struct {
    logic [Q_W-1:0]   q;
    logic [TAG_W-1:0] tag;
    logic             dz;
    int               wr_edge;
  } ent_t;

  ent_t pend[$];
  ent_t fq[$];
  int   edge_no = 0;
  int   same_edge_hits = 0;

  always @(negedge clk) begin : mon
    ent_t        e;
    bit          acc, pop, wr;
    logic [63:0] t;
    if (reset) begin
      pend.delete();
      fq.delete();
    end else begin
      acc = req_valid && (pend.size() + fq.size() < DEPTH);
      pop = (fq.size() != 0) && rsp_ready;
      wr  = (pend.size() != 0) && (pend[0].wr_edge == edge_no);
      if (acc && pop && wr) same_edge_hits++;
      if (pop) void'(fq.pop_front());
      if (wr) fq.push_back(pend.pop_front());
      if (fq.size() > DEPTH) chk("model_overflow", fq.size(), DEPTH);
      if (acc) begin
        e.tag = req_tag;
        e.dz  = (req_b == '0);
        t     = e.dz ? 64'd0 : req_a / {13'd0, req_b};
        e.q   = e.dz ? '1 : t[Q_W-1:0];
        e.wr_edge = edge_no + DIV_LAT + 1;
        pend.push_back(e);
      end
    end
    edge_no++;
    chk("req_ready", req_ready, !reset && (pend.size() + fq.size() < DEPTH));
    chk("rsp_valid", rsp_valid, fq.size() != 0);
    chk("inflight", inflight, pend.size());
    if (fq.size() != 0) begin
      chk("rsp_q", rsp_q, fq[0].q);
      chk("rsp_tag", rsp_tag, fq[0].tag);
      chk("rsp_dz", rsp_dz, fq[0].dz);
    end else if (reset) begin
      chk("rst_rsp_q", rsp_q, 0);
      chk("rst_rsp_tag", rsp_tag, 0);
      chk("rst_rsp_dz", rsp_dz, 0);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Issue one request on an idle sequencer and wait for its response to reach the FIFO head.
  task automatic single(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                        input logic [TAG_W-1:0] tag, output int lat);
    req_valid = 1'b1; req_a = a; req_b = b; req_tag = tag;
    chk("single_ready", req_ready, 1);
    cyc();
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      cyc();
      lat++;
    end
  endtask

  task automatic pop_one();
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int lat, acc, n, cycles, errs;
    logic [TAG_W-1:0] sent[$];
    logic [TAG_W-1:0] got[$];

    cyc(); cyc();
    chk("reset_ready", req_ready, 0);
    chk("reset_inflight", inflight, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    reset = 1'b0;
    cyc();
    chk("ready_after_release", req_ready, 1);

    single(64'd100, 51'd7, 4'd3, lat);
    chk("t1_latency", lat, 33);
    chk("t1_q", rsp_q, 14);
    chk("t1_tag", rsp_tag, 3);
    chk("t1_dz", rsp_dz, 0);
    chk("t1_inflight", inflight, 0);
    pop_one();
    chk("t1_drained", rsp_valid, 0);

    single(64'd12345, 51'd0, 4'd5, lat);
    chk("t2_latency", lat, 33);
    chk("t2_q", rsp_q, 32'hFFFF_FFFF);
    chk("t2_tag", rsp_tag, 5);
    chk("t2_dz", rsp_dz, 1);
    pop_one();

    acc = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_a = 64'(1000 + i); req_b = 51'd3; req_tag = 4'(i);
      if (req_ready) acc++;
      cyc();
    end
    req_valid = 1'b0;
    chk("t3_accepts", acc, 8);
    chk("t3_ready_low", req_ready, 0);
    repeat (40) cyc();
    chk("t3_inflight", inflight, 0);
    chk("t3_ready_full", req_ready, 0);
    chk("t3_q0", rsp_q, 333);
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_valid", rsp_valid, 1);
      chk("t3_tag_order", rsp_tag, i);
      cyc();
      if (i == 0) chk("t3_credit_return", req_ready, 1);
    end
    rsp_ready = 1'b0;
    chk("t3_empty", rsp_valid, 0);

    rsp_ready = 1'b1;
    n = 0; cycles = 0;
    while ((n < 200 || got.size() < 200) && cycles < 3000) begin
      if (rsp_valid) got.push_back(rsp_tag);
      req_valid = (n < 200);
      req_tag = 4'(n % 16);
      req_a   = 64'(n * 977 + 5);
      req_b   = (n % 29 == 0) ? 51'd0 : 51'((n % 13) + 1);
      if (req_valid && req_ready) begin
        sent.push_back(req_tag);
        n++;
      end
      cyc();
      cycles++;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("t4_no_timeout", cycles < 3000, 1);
    chk("t4_rate", cycles < 1000, 1);
    chk("t4_got_count", got.size(), 200);
    errs = 0;
    for (int i = 0; i < 200 && i < got.size(); i++) if (got[i] !== sent[i]) errs++;
    chk("t4_order", errs, 0);
    chk("t5_same_edge_seen", same_edge_hits > 0, 1);

    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_a = 64'(50 + i); req_b = 51'd5; req_tag = 4'(9 + i);
      chk("t6_accept_ready", req_ready, 1);
      cyc();
    end
    req_valid = 1'b0;
    repeat (10) cyc();
    reset = 1'b1;
    cyc();
    chk("t6_ready_in_reset", req_ready, 0);
    chk("t6_inflight_in_reset", inflight, 0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("t6_ready_after", req_ready, 1);
    for (int i = 0; i < 40; i++) begin
      chk("t6_no_rsp", rsp_valid, 0);
      chk("t6_inflight", inflight, 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
